// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM state encoding, default bit timing and
// frame-length constants. Build option UART_TX_PARITY_EN adds an even-parity
// bit and the matching PARITY state.
package uart_pkg;

    // 100 MHz / 115200 baud
    localparam int unsigned ClksPerBitDefault = 868;
    localparam int unsigned DataBits          = 8;

`ifdef UART_TX_PARITY_EN
    localparam int unsigned FrameBits = 11;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_tx_state_e;
`else
    localparam int unsigned FrameBits = 10;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_tx_state_e;
`endif

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO for the UART transmitter: circular storage, read/write pointers
// and an occupancy count. Pushes to a full FIFO and pops from an empty FIFO
// are ignored.
module uart_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW  = AddrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    // Full is judged before any same-edge pop, so a write to a full FIFO is lost.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Next pointers and count; pointers wrap naturally since Depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AddrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AddrW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful between push and pop, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serialiser (8E1 when
// UART_TX_PARITY_EN is defined). Back-to-back frames have no idle gap; the
// serial line is registered, so it follows the FSM state by one clock.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic       CLK100MHZ,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       busy,
    output logic       overflow,
    output logic       uart_rxd_out
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudReload = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LastBit = 3'(DataBits - 1);

    uart_tx_state_e   state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif
    logic             line_q, line_d;
    logic             overflow_q, overflow_d;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic             bit_done;

    uart_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (8)
    ) u_fifo (
        .clk_i   (CLK100MHZ),
        .rst_i   (rst),
        .push_i  (wr_en),
        .data_i  (wr_data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bit_done     = (baud_q == '0);
    assign full         = fifo_full;
    assign busy         = ~((state_q == StIdle) & fifo_empty);
    assign overflow     = overflow_q;
    assign uart_rxd_out = line_q;

    // Sticky overflow: any write presented while full is dropped.
    assign overflow_d = overflow_q | (wr_en & fifo_full);

    // FSM next state, baud timing, shifter and FIFO pop.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        fifo_pop  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
`ifdef UART_TX_PARITY_EN
                    parity_d = even_parity(fifo_head);
`endif
                    baud_d   = BaudReload;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    baud_d    = BaudReload;
                    bit_idx_d = '0;
                    state_d   = StData;
                end else begin
                    baud_d = baud_q - BaudW'(1);
                end
            end
            StData: begin
                if (bit_done) begin
                    baud_d  = BaudReload;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == LastBit) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BaudW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_done) begin
                    baud_d  = BaudReload;
                    state_d = StStop;
                end else begin
                    baud_d = baud_q - BaudW'(1);
                end
            end
`endif
            StStop: begin
                if (bit_done) begin
                    // Chain straight into the next start bit when bytes are waiting.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
`ifdef UART_TX_PARITY_EN
                        parity_d = even_parity(fifo_head);
`endif
                        baud_d   = BaudReload;
                        state_d  = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q - BaudW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Serial line level for the current state; registered below.
    always_comb begin
        line_d = 1'b1;
        unique case (state_q)
            StIdle:   line_d = 1'b1;
            StStart:  line_d = 1'b0;
            StData:   line_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            StParity: line_d = parity_q;
`endif
            StStop:   line_d = 1'b1;
            default:  line_d = 1'b1;
        endcase
    end

    // State, timing, shifter, line and overflow registers with synchronous reset.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
            line_q     <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
            line_q     <= line_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clocks per UART bit (100 MHz / 115200).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, giving byte-FIFO entries (power of two, >=2).
REQ-003 The block SHALL have port CLK100MHZ, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit: byte-write strobe from the memory manager's UART data-register store.
REQ-006 The block SHALL have port wr_data, input, 8 bits: byte to transmit.
REQ-007 The block SHALL have port full, output, 1 bit: FIFO holds FIFO_DEPTH bytes.
REQ-008 The block SHALL have port busy, output, 1 bit: FIFO non-empty or frame in progress.
REQ-009 The block SHALL have port overflow, output, 1 bit: sticky flag; a write was dropped.
REQ-010 The block SHALL have port uart_rxd_out, output, 1 bit: registered serial line to the host, idle high.

Function
REQ-011 A write SHALL be accepted on a rising edge with wr_en=1 and full=0; wr_data is stored at the tail.
REQ-012 A write with full=1 SHALL be dropped and set overflow, even if a pop occurs on the same edge.
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY (only with the macro), and STOP.
REQ-014 In IDLE with the FIFO non-empty, the FSM SHALL pop the head on the next edge, load the shift register, enter START, and drive uart_rxd_out=0.
REQ-015 The start bit SHALL begin on the second edge after the accepting edge when the block was idle and empty.
REQ-016 Every bit SHALL last exactly CLKS_PER_BIT clocks, timed by a baud counter reloaded at each bit boundary.
REQ-017 DATA SHALL send 8 bits LSB first, with a 3-bit index; after bit 7 the FSM enters PARITY if enabled, else STOP.
REQ-018 STOP SHALL drive 1 for one bit time.
REQ-019 At the end of STOP, a non-empty FIFO SHALL cause a direct entry to START with the popped byte (no idle gap); otherwise the FSM enters IDLE.
REQ-020 A simultaneous accepted write and pop SHALL leave the count unchanged; the FIFO SHALL never pop when empty.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 full SHALL be derived from an occupancy count of width clog2(FIFO_DEPTH)+1.
REQ-023 busy SHALL be 0 only when the FSM is in IDLE and the count is 0.
REQ-024 Bytes SHALL be transmitted in write order; a frame, once started, SHALL never be truncated except by rst.

Reset
REQ-025 With rst=1 on an edge, the block SHALL enter IDLE and clear the count, pointers, baud counter, bit index, and overflow.
REQ-026 Reset SHALL force uart_rxd_out=1, full=0, and busy=0 on the following cycle.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately and discard all queued bytes.
REQ-028 FIFO storage contents SHALL need no reset.

Configuration
REQ-029 With UART_TX_PARITY_EN defined, the block SHALL insert an even-parity bit (XOR of the 8 data bits) between DATA and STOP, making the frame 11 bits.
REQ-030 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, and the frame SHALL be 10 bits (8N1).

Structure
REQ-031 The shared package uart_pkg SHALL hold the FSM state encodings, the default CLKS_PER_BIT, and the frame-length constants.
REQ-032 Byte storage, pointers, and count SHALL be one sub-module, uart_fifo (push/pop/full/empty); the FSM and shifter SHALL live in uart_tx_fifo.

Verification (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4, macro off unless stated)
REQ-033 Write 0xA5 when idle -> line low 2 edges later, then bits 1,0,1,0,0,1,0,1, then 1; each level held 4 clocks, 40 clocks total; then busy=0.
REQ-034 Write 0x01,0x02,0x03 on consecutive cycles -> three back-to-back frames, stop bit immediately followed by start bit, bytes in order, 120 clocks.
REQ-035 Five writes while the first frame is in progress -> full=1 after the fourth queued byte, the fifth is dropped, overflow=1 and stays 1 until rst.
REQ-036 Assert rst during DATA bit 3 of 0xFF with 2 bytes queued -> next cycle line=1, busy=0, full=0, and no further frames.
REQ-037 UART_TX_PARITY_EN defined, write 0x07 -> start, 1,1,1,0,0,0,0,0, parity 1, stop; 44 clocks.
REQ-038 Write on the same edge as the pop of a full FIFO -> write dropped, overflow=1, count decrements by one.
